exception_commit: RTL and testbench
===================================

// Module: exception_commit
// PURPOSE
//  Precise-exception commit stage between memory stage and CP0. Prioritises the oldest instruction's exception flags
//  and pending interrupt, drives the CP0 exception write (en_exp/ewr_*), and selects the handler from CP0's vector outputs.
//  Issues a one-cycle pipeline flush and a held fetch redirect.
// PARAMETERS
//  BD_EPC_OFFSET  4  subtracted from pc for EPC when the instruction is in a delay slot
//  INT_ON_BD      1  1: interrupts may be taken on a delay-slot instruction; 0: deferred to next instruction
// PORTS
//  clk                 in   1   clock
//  resetn              in   1   asynchronous active-low reset
//  req_valid_i         in   1   instruction at commit point
//  req_ready_o         out  1   stage accepts request (IDLE only)
//  req_pc_i            in   32  instruction pc
//  req_bd_i            in   1   instruction is in a branch delay slot
//  req_eret_i          in   1   instruction is ERET
//  req_is_store_i      in   1   memory op is a store (selects TLBS vs TLBL)
//  req_flags_i         in   13  [0]if_adel [1]if_refill [2]if_tlbinv [3]ri [4]cpu [5]ov [6]sys [7]bp [8]mem_adel [9]mem_ades [10]mem_refill [11]mem_tlbinv [12]mem_mod
//  req_mem_addr_i      in   32  data virtual address
//  interrupt_pending_i in   1   from CP0
//  epc_i, exc_handler_i, int_handler_i, tlb_refill_handler_i  in 32 each  from CP0
//  en_exp_o            out  1   CP0 exception write strobe
//  ewr_bd_o            out  1   Cause.BD value
//  ewr_epc_o           out  32  EPC value
//  ewr_badVAddr_o      out  32  BadVAddr value
//  ewr_excCode_o       out  5   ExcCode_t (cERET for ERET)
//  flush_o             out  1   kill all younger pipeline stages
//  redirect_valid_o    out  1   new fetch pc valid
//  redirect_ready_i    in   1   fetch accepted redirect
//  redirect_pc_o       out  32  new fetch pc
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready_o=1. Async reset mid-operation aborts immediately, no CP0 write.
//  FSM IDLE -> COMMIT -> REDIRECT -> IDLE.
//  IDLE: req_ready_o=1. Accept on req_valid_i. "Action" = take_int | (|req_flags_i) | req_eret_i,
//   take_int = interrupt_pending_i & (INT_ON_BD | ~req_bd_i). Action: latch code/bd/epc/badvaddr/vector-kind, go COMMIT.
//   No action: instruction retires, stay IDLE.
//  Priority (highest first): Int(0) > if_adel AdEL(4) > if_refill/if_tlbinv TLBL(2) > ri RI(10) > cpu CpU(11) >
//   ov Ov(12) > sys Sys(8) > bp Bp(9) > mem_adel AdEL(4) > mem_ades AdES(5) > mem_refill/mem_tlbinv TLBL(2)/TLBS(3) > mem_mod Mod(1) > ERET.
//  EPC = req_bd_i ? req_pc_i-BD_EPC_OFFSET : req_pc_i (32-bit wrap). ewr_bd_o = req_bd_i.
//  BadVAddr: fetch-class codes -> req_pc_i; mem-class -> req_mem_addr_i; others 0.
//  COMMIT (exactly 1 cycle): en_exp_o=1, flush_o=1, redirect_valid_o=1, ewr_* from latches.
//   redirect_pc_o combinational from CP0 this cycle (EXL still pre-exception; mtc0 of previous cycle visible):
//   Int->int_handler_i; if_refill/mem_refill winner->tlb_refill_handler_i; ERET->epc_i; else exc_handler_i.
//   redirect_pc_o latched at end of COMMIT. If redirect_ready_i -> IDLE, else -> REDIRECT.
//  REDIRECT: en_exp_o=0, flush_o=0; redirect_valid_o=1, redirect_pc_o=latched, held stable until redirect_ready_i, then IDLE.
//  req_ready_o=0 in COMMIT and REDIRECT; upstream holds. en_exp_o/flush_o never asserted more than one cycle per event.
//  ERET: ewr_excCode_o=cERET, ewr_bd_o/epc/badvaddr = 0 (CP0 ignores them).
//  interrupt_pending_i without req_valid_i: not taken (EPC imprecise).
//  Latency: accept at T -> en_exp_o/flush_o/redirect at T+1 -> earliest next accept T+2.
// TESTING
//  1 sys at pc=0x8000_1000, bd=0 -> T+1: en_exp=1, code=8, epc=0x8000_1000, redirect=exc_handler_i (0x8000_0180).
//  2 mem_refill, store, pc=0x8000_2004, bd=1, addr=0x0040_0010 -> code=3, bd=1, epc=0x8000_2000, badva=0x0040_0010, redirect=tlb_refill_handler_i.
//  3 interrupt_pending + ov + if_adel together -> code=0, redirect=int_handler_i; INT_ON_BD=0 with bd=1 -> code=12 instead.
//  4 ERET with epc_i=0xBFC0_0380 -> code=cERET, flush=1, redirect=0xBFC0_0380.
//  5 redirect_ready_i low 3 cycles -> redirect_pc stable, req_ready=0, en_exp single pulse; ready at 4th -> IDLE.
//  6 resetn low during REDIRECT -> all outputs 0 asynchronously, req_ready=1 after release, no further en_exp.

Source files
------------

// File: rtl/exception_commit_if.sv
// Commit-stage bus: instruction request, CP0 exception write/vectors, and fetch redirect.
// Master is the pipeline/CP0/fetch environment; slave is the commit stage itself.
// Signals keep their _i/_o suffixes as seen from the commit stage.
interface exception_commit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_pc_i;
  logic        req_bd_i;
  logic        req_eret_i;
  logic        req_is_store_i;
  logic [12:0] req_flags_i;
  logic [31:0] req_mem_addr_i;
  logic        interrupt_pending_i;
  logic [31:0] epc_i;
  logic [31:0] exc_handler_i;
  logic [31:0] int_handler_i;
  logic [31:0] tlb_refill_handler_i;
  logic        en_exp_o;
  logic        ewr_bd_o;
  logic [31:0] ewr_epc_o;
  logic [31:0] ewr_badVAddr_o;
  logic [4:0]  ewr_excCode_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic        redirect_ready_i;
  logic [31:0] redirect_pc_o;

  modport master (
    output req_valid_i, req_pc_i, req_bd_i, req_eret_i, req_is_store_i, req_flags_i,
           req_mem_addr_i, interrupt_pending_i, epc_i, exc_handler_i, int_handler_i,
           tlb_refill_handler_i, redirect_ready_i,
    input  req_ready_o, en_exp_o, ewr_bd_o, ewr_epc_o, ewr_badVAddr_o, ewr_excCode_o,
           flush_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  req_valid_i, req_pc_i, req_bd_i, req_eret_i, req_is_store_i, req_flags_i,
           req_mem_addr_i, interrupt_pending_i, epc_i, exc_handler_i, int_handler_i,
           tlb_refill_handler_i, redirect_ready_i,
    output req_ready_o, en_exp_o, ewr_bd_o, ewr_epc_o, ewr_badVAddr_o, ewr_excCode_o,
           flush_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/exception_commit.sv
// Precise-exception commit: prioritise oldest instruction's exceptions/interrupt, write CP0, flush, redirect fetch.
// Latency: accept at T, CP0 write + flush + redirect at T+1, earliest next accept at T+2.
// Backpressure: req_ready_o low outside IDLE; redirect held stable until redirect_ready_i.
module exception_commit #(
  parameter logic [31:0] BD_EPC_OFFSET = 32'd4,
  parameter bit          INT_ON_BD     = 1'b1,
  parameter logic [4:0]  EXC_ERET      = 5'h1f
) (
  input  logic               clk,
  input  logic               resetn,
  exception_commit_if.slave  bus
);

  localparam logic [4:0] C_INT  = 5'd0;
  localparam logic [4:0] C_MOD  = 5'd1;
  localparam logic [4:0] C_TLBL = 5'd2;
  localparam logic [4:0] C_TLBS = 5'd3;
  localparam logic [4:0] C_ADEL = 5'd4;
  localparam logic [4:0] C_ADES = 5'd5;
  localparam logic [4:0] C_SYS  = 5'd8;
  localparam logic [4:0] C_BP   = 5'd9;
  localparam logic [4:0] C_RI   = 5'd10;
  localparam logic [4:0] C_CPU  = 5'd11;
  localparam logic [4:0] C_OV   = 5'd12;

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_REDIRECT} state_t;
  typedef enum logic [1:0] {V_EXC, V_INT, V_REFILL, V_ERET} vec_t;

  state_t      r_state, w_next;
  logic [4:0]  r_code;
  logic        r_bd;
  logic [31:0] r_epc, r_badva, r_redir_pc;
  vec_t        r_vec;

  logic        w_take_int, w_act, w_eret, w_accept;
  logic [4:0]  w_code;
  logic [31:0] w_epc, w_badva, w_commit_pc;
  vec_t        w_vec;
  logic [12:0] w_f;

  assign w_f        = bus.req_flags_i;
  assign w_take_int = bus.interrupt_pending_i & (INT_ON_BD | ~bus.req_bd_i);
  assign w_epc      = bus.req_bd_i ? (bus.req_pc_i - BD_EPC_OFFSET) : bus.req_pc_i;
  assign w_accept   = (r_state == S_IDLE) & bus.req_valid_i & w_act;

  // Pick the winning exception by priority; ERET is lowest, nothing set means plain retire.
  always_comb begin
    w_act   = 1'b1;
    w_eret  = 1'b0;
    w_code  = C_INT;
    w_badva = 32'd0;
    w_vec   = V_EXC;
    if (w_take_int) begin
      w_vec = V_INT;
    end else if (w_f[0]) begin
      w_code = C_ADEL; w_badva = bus.req_pc_i;
    end else if (w_f[1] | w_f[2]) begin
      w_code = C_TLBL; w_badva = bus.req_pc_i; w_vec = w_f[1] ? V_REFILL : V_EXC;
    end else if (w_f[3]) begin
      w_code = C_RI;
    end else if (w_f[4]) begin
      w_code = C_CPU;
    end else if (w_f[5]) begin
      w_code = C_OV;
    end else if (w_f[6]) begin
      w_code = C_SYS;
    end else if (w_f[7]) begin
      w_code = C_BP;
    end else if (w_f[8]) begin
      w_code = C_ADEL; w_badva = bus.req_mem_addr_i;
    end else if (w_f[9]) begin
      w_code = C_ADES; w_badva = bus.req_mem_addr_i;
    end else if (w_f[10] | w_f[11]) begin
      w_code  = bus.req_is_store_i ? C_TLBS : C_TLBL;
      w_badva = bus.req_mem_addr_i;
      w_vec   = w_f[10] ? V_REFILL : V_EXC;
    end else if (w_f[12]) begin
      w_code = C_MOD; w_badva = bus.req_mem_addr_i;
    end else if (bus.req_eret_i) begin
      w_code = EXC_ERET; w_vec = V_ERET; w_eret = 1'b1;
    end else begin
      w_act = 1'b0;
    end
  end

  // Handler address is read from CP0 in the COMMIT cycle, before CP0 sees the exception write.
  always_comb begin
    case (r_vec)
      V_INT:    w_commit_pc = bus.int_handler_i;
      V_REFILL: w_commit_pc = bus.tlb_refill_handler_i;
      V_ERET:   w_commit_pc = bus.epc_i;
      default:  w_commit_pc = bus.exc_handler_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = S_COMMIT;
      S_COMMIT:   w_next = bus.redirect_ready_i ? S_IDLE : S_REDIRECT;
      S_REDIRECT: if (bus.redirect_ready_i) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Capture the exception record on accept and the redirect target at the end of COMMIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_code     <= 5'd0;
      r_bd       <= 1'b0;
      r_epc      <= 32'd0;
      r_badva    <= 32'd0;
      r_vec      <= V_EXC;
      r_redir_pc <= 32'd0;
    end else begin
      if (w_accept) begin
        r_code  <= w_code;
        r_bd    <= w_eret ? 1'b0 : bus.req_bd_i;
        r_epc   <= w_eret ? 32'd0 : w_epc;
        r_badva <= w_badva;
        r_vec   <= w_vec;
      end
      if (r_state == S_COMMIT) r_redir_pc <= w_commit_pc;
    end
  end

  // Outputs decoded from state; CP0 write and flush exist only in COMMIT.
  always_comb begin
    bus.req_ready_o      = 1'b0;
    bus.en_exp_o         = 1'b0;
    bus.flush_o          = 1'b0;
    bus.redirect_valid_o = 1'b0;
    bus.redirect_pc_o    = 32'd0;
    bus.ewr_bd_o         = 1'b0;
    bus.ewr_epc_o        = 32'd0;
    bus.ewr_badVAddr_o   = 32'd0;
    bus.ewr_excCode_o    = 5'd0;
    case (r_state)
      S_IDLE: bus.req_ready_o = 1'b1;
      S_COMMIT: begin
        bus.en_exp_o         = 1'b1;
        bus.flush_o          = 1'b1;
        bus.redirect_valid_o = 1'b1;
        bus.redirect_pc_o    = w_commit_pc;
        bus.ewr_bd_o         = r_bd;
        bus.ewr_epc_o        = r_epc;
        bus.ewr_badVAddr_o   = r_badva;
        bus.ewr_excCode_o    = r_code;
      end
      S_REDIRECT: begin
        bus.redirect_valid_o = 1'b1;
        bus.redirect_pc_o    = r_redir_pc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exception_commit.sv
// Bench for exception_commit: directed vector table, hand-written reset corner, randomized run vs. rule model.
// Two instances: INT_ON_BD=1 (u0) and INT_ON_BD=0 (u1), driven with identical stimulus.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_exception_commit;
  localparam logic [4:0]  C_ERET = 5'h1f;
  localparam logic [31:0] EXC_H  = 32'h8000_0180;
  localparam logic [31:0] INT_H  = 32'h8000_0200;
  localparam logic [31:0] TLB_H  = 32'h8000_0000;

  typedef struct {
    logic [31:0] pc; logic bd; logic eret; logic store; logic [12:0] flags;
    logic [31:0] addr; logic intp; logic [31:0] epc_in; int delay;
  } req_t;
  typedef struct {
    logic act; logic [4:0] code; logic bd; logic [31:0] epc; logic [31:0] badva; logic [31:0] vec;
  } exp_t;
  typedef struct { req_t r; exp_t e0; exp_t e1; } vec_rec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exception_commit_if if0();
  exception_commit_if if1();

  exception_commit #(.INT_ON_BD(1'b1)) u0 (.clk(clk), .resetn(resetn), .bus(if0));
  exception_commit #(.INT_ON_BD(1'b0)) u1 (.clk(clk), .resetn(resetn), .bus(if1));

  int checks = 0;
  int errors = 0;
  int en_cnt0 = 0, en_cnt1 = 0, en_exp0 = 0, en_exp1 = 0;

  always @(posedge clk) begin
    if (if0.en_exp_o) en_cnt0 <= en_cnt0 + 1;
    if (if1.en_exp_o) en_cnt1 <= en_cnt1 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic act, input logic [4:0] code, input logic bd,
                              input logic [31:0] epc, input logic [31:0] badva, input logic [31:0] vec);
    exp_t e;
    e.act = act; e.code = code; e.bd = bd; e.epc = epc; e.badva = badva; e.vec = vec;
    return e;
  endfunction

  function automatic req_t mkreq(input logic [31:0] pc, input logic bd, input logic eret, input logic store,
                                 input logic [12:0] flags, input logic [31:0] addr, input logic intp,
                                 input logic [31:0] epc_in, input int delay);
    req_t r;
    r.pc = pc; r.bd = bd; r.eret = eret; r.store = store; r.flags = flags;
    r.addr = addr; r.intp = intp; r.epc_in = epc_in; r.delay = delay;
    return r;
  endfunction

  // Reference: walk a priority list of (condition, code, address class) and take the first hit.
  function automatic exp_t model(input req_t r, input bit int_on_bd);
    exp_t e;
    bit hit[13];
    logic [4:0] code[13];
    int cls[13];
    bit found;
    e = mk(0, 0, 0, 0, 0, 0);
    hit[0] = r.intp && (int_on_bd || !r.bd);
    hit[1] = r.flags[0];
    hit[2] = r.flags[1] | r.flags[2];
    for (int i = 3; i <= 7; i++) hit[i] = r.flags[i];
    hit[8]  = r.flags[8];
    hit[9]  = r.flags[9];
    hit[10] = r.flags[10] | r.flags[11];
    hit[11] = r.flags[12];
    hit[12] = r.eret;
    code = '{5'd0, 5'd4, 5'd2, 5'd10, 5'd11, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5,
             (r.store ? 5'd3 : 5'd2), 5'd1, C_ERET};
    cls  = '{0, 1, 1, 0, 0, 0, 0, 0, 2, 2, 2, 2, 0};
    found = 0;
    for (int i = 0; i < 13; i++) begin
      if (hit[i] && !found) begin
        found = 1;
        e.act = 1; e.code = code[i];
        if (i == 12) begin
          e.vec = r.epc_in;
        end else begin
          e.bd    = r.bd;
          e.epc   = r.bd ? r.pc - 32'd4 : r.pc;
          e.badva = (cls[i] == 1) ? r.pc : (cls[i] == 2) ? r.addr : 32'd0;
          if (i == 0) e.vec = INT_H;
          else if ((i == 2 && r.flags[1]) || (i == 10 && r.flags[10])) e.vec = TLB_H;
          else e.vec = EXC_H;
        end
      end
    end
    return e;
  endfunction

  task automatic apply(input req_t r, input logic v);
    if0.req_valid_i = v; if0.req_pc_i = r.pc; if0.req_bd_i = r.bd; if0.req_eret_i = r.eret;
    if0.req_is_store_i = r.store; if0.req_flags_i = r.flags; if0.req_mem_addr_i = r.addr;
    if0.interrupt_pending_i = r.intp; if0.epc_i = r.epc_in;
    if1.req_valid_i = v; if1.req_pc_i = r.pc; if1.req_bd_i = r.bd; if1.req_eret_i = r.eret;
    if1.req_is_store_i = r.store; if1.req_flags_i = r.flags; if1.req_mem_addr_i = r.addr;
    if1.interrupt_pending_i = r.intp; if1.epc_i = r.epc_in;
  endtask

  task automatic set_valid(input logic v);
    if0.req_valid_i = v; if1.req_valid_i = v;
  endtask

  task automatic set_rdy(input logic v);
    if0.redirect_ready_i = v; if1.redirect_ready_i = v;
  endtask

  // ph: 0 idle, 1 commit, 2 redirect hold.
  task automatic chk_phase(input int w, input int ph, input exp_t e, input string tag);
    logic rdy, en, fl, rv, ebd;
    logic [4:0] code;
    logic [31:0] epc, bva, rpc;
    string p;
    p = $sformatf("%s u%0d", tag, w);
    if (w == 0) begin
      rdy = if0.req_ready_o; en = if0.en_exp_o; fl = if0.flush_o; rv = if0.redirect_valid_o;
      ebd = if0.ewr_bd_o; code = if0.ewr_excCode_o; epc = if0.ewr_epc_o;
      bva = if0.ewr_badVAddr_o; rpc = if0.redirect_pc_o;
    end else begin
      rdy = if1.req_ready_o; en = if1.en_exp_o; fl = if1.flush_o; rv = if1.redirect_valid_o;
      ebd = if1.ewr_bd_o; code = if1.ewr_excCode_o; epc = if1.ewr_epc_o;
      bva = if1.ewr_badVAddr_o; rpc = if1.redirect_pc_o;
    end
    chk({p, " req_ready"}, {31'd0, rdy}, (ph == 0) ? 32'd1 : 32'd0);
    chk({p, " en_exp"},    {31'd0, en},  (ph == 1) ? 32'd1 : 32'd0);
    chk({p, " flush"},     {31'd0, fl},  (ph == 1) ? 32'd1 : 32'd0);
    chk({p, " redir_vld"}, {31'd0, rv},  (ph != 0) ? 32'd1 : 32'd0);
    if (ph == 1) begin
      chk({p, " excCode"}, {27'd0, code}, {27'd0, e.code});
      chk({p, " ewr_bd"},  {31'd0, ebd},  {31'd0, e.bd});
      chk({p, " ewr_epc"}, epc, e.epc);
      chk({p, " badva"},   bva, e.badva);
    end
    if (ph != 0) chk({p, " redir_pc"}, rpc, e.vec);
  endtask

  task automatic run_req(input string tag, input req_t r, input exp_t e0, input exp_t e1);
    @(negedge clk);
    apply(r, 1'b1);
    set_rdy(r.delay == 0);
    chk_phase(0, 0, e0, {tag, " pre"});
    chk_phase(1, 0, e1, {tag, " pre"});
    @(negedge clk);
    set_valid(1'b0);
    chk_phase(0, e0.act ? 1 : 0, e0, {tag, " commit"});
    chk_phase(1, e1.act ? 1 : 0, e1, {tag, " commit"});
    en_exp0 += int'(e0.act);
    en_exp1 += int'(e1.act);
    for (int k = 1; k <= r.delay; k++) begin
      @(negedge clk);
      chk_phase(0, e0.act ? 2 : 0, e0, $sformatf("%s hold%0d", tag, k));
      chk_phase(1, e1.act ? 2 : 0, e1, $sformatf("%s hold%0d", tag, k));
      if (k == r.delay) set_rdy(1'b1);
    end
    @(negedge clk);
    chk_phase(0, 0, e0, {tag, " post"});
    chk_phase(1, 0, e1, {tag, " post"});
  endtask

  vec_rec_t tbl[12];
  exp_t none_e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    exp_t e;
    none_e = mk(0, 0, 0, 0, 0, 0);
    tbl[0]  = '{mkreq(32'h8000_1000, 0, 0, 0, 13'h0040, 32'h0, 0, 32'h0, 0),
                mk(1, 5'd8, 0, 32'h8000_1000, 32'h0, EXC_H), mk(1, 5'd8, 0, 32'h8000_1000, 32'h0, EXC_H)};
    tbl[1]  = '{mkreq(32'h8000_2004, 1, 0, 1, 13'h0400, 32'h0040_0010, 0, 32'h0, 0),
                mk(1, 5'd3, 1, 32'h8000_2000, 32'h0040_0010, TLB_H), mk(1, 5'd3, 1, 32'h8000_2000, 32'h0040_0010, TLB_H)};
    tbl[2]  = '{mkreq(32'h8000_3000, 0, 0, 0, 13'h0021, 32'h1234, 1, 32'h0, 1),
                mk(1, 5'd0, 0, 32'h8000_3000, 32'h0, INT_H), mk(1, 5'd0, 0, 32'h8000_3000, 32'h0, INT_H)};
    tbl[3]  = '{mkreq(32'h8000_3008, 1, 0, 0, 13'h0020, 32'h0, 1, 32'h0, 0),
                mk(1, 5'd0, 1, 32'h8000_3004, 32'h0, INT_H), mk(1, 5'd12, 1, 32'h8000_3004, 32'h0, EXC_H)};
    tbl[4]  = '{mkreq(32'h8000_5000, 1, 1, 0, 13'h0, 32'hDEAD_BEEF, 0, 32'hBFC0_0380, 0),
                mk(1, C_ERET, 0, 32'h0, 32'h0, 32'hBFC0_0380), mk(1, C_ERET, 0, 32'h0, 32'h0, 32'hBFC0_0380)};
    tbl[5]  = '{mkreq(32'h8000_4000, 0, 0, 0, 13'h0008, 32'h0, 0, 32'h0, 3),
                mk(1, 5'd10, 0, 32'h8000_4000, 32'h0, EXC_H), mk(1, 5'd10, 0, 32'h8000_4000, 32'h0, EXC_H)};
    tbl[6]  = '{mkreq(32'h8000_6000, 1, 0, 0, 13'h0, 32'h55, 0, 32'h0, 0), none_e, none_e};
    tbl[7]  = '{mkreq(32'h8000_7004, 1, 0, 0, 13'h0, 32'h0, 1, 32'h0, 2),
                mk(1, 5'd0, 1, 32'h8000_7000, 32'h0, INT_H), none_e};
    tbl[8]  = '{mkreq(32'h0000_0000, 1, 0, 0, 13'h000A, 32'h0, 0, 32'h0, 0),
                mk(1, 5'd2, 1, 32'hFFFF_FFFC, 32'h0, TLB_H), mk(1, 5'd2, 1, 32'hFFFF_FFFC, 32'h0, TLB_H)};
    tbl[9]  = '{mkreq(32'h8000_8000, 0, 0, 0, 13'h1800, 32'h0000_3000, 0, 32'h0, 0),
                mk(1, 5'd2, 0, 32'h8000_8000, 32'h3000, EXC_H), mk(1, 5'd2, 0, 32'h8000_8000, 32'h3000, EXC_H)};
    tbl[10] = '{mkreq(32'h8000_8800, 0, 0, 1, 13'h1000, 32'h7000_0004, 0, 32'h0, 0),
                mk(1, 5'd1, 0, 32'h8000_8800, 32'h7000_0004, EXC_H), mk(1, 5'd1, 0, 32'h8000_8800, 32'h7000_0004, EXC_H)};
    tbl[11] = '{mkreq(32'h8000_9000, 0, 0, 0, 13'h0280, 32'h44, 0, 32'h0, 0),
                mk(1, 5'd9, 0, 32'h8000_9000, 32'h0, EXC_H), mk(1, 5'd9, 0, 32'h8000_9000, 32'h0, EXC_H)};

    if0.exc_handler_i = EXC_H; if0.int_handler_i = INT_H; if0.tlb_refill_handler_i = TLB_H;
    if1.exc_handler_i = EXC_H; if1.int_handler_i = INT_H; if1.tlb_refill_handler_i = TLB_H;
    apply(mkreq(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    set_rdy(1'b1);

    // Reset state.
    @(negedge clk);
    chk_phase(0, 0, none_e, "reset");
    chk_phase(1, 0, none_e, "reset");
    chk("reset excCode u0", {27'd0, if0.ewr_excCode_o}, 32'd0);
    chk("reset redir_pc u0", if0.redirect_pc_o, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) run_req($sformatf("vec%0d", i), tbl[i].r, tbl[i].e0, tbl[i].e1);

    // Reset asserted while holding a redirect: outputs drop at once, no CP0 write afterwards.
    @(negedge clk);
    apply(mkreq(32'h8000_A000, 0, 0, 0, 13'h0040, 32'h0, 0, 32'h0, 0), 1'b1);
    set_rdy(1'b0);
    @(negedge clk);
    set_valid(1'b0);
    e = mk(1, 5'd8, 0, 32'h8000_A000, 32'h0, EXC_H);
    chk_phase(0, 1, e, "rst commit");
    en_exp0++; en_exp1++;
    @(negedge clk);
    chk_phase(0, 2, e, "rst hold");
    #2 resetn = 1'b0;
    #1;
    chk("rst async redir_vld", {31'd0, if0.redirect_valid_o}, 32'd0);
    chk("rst async en_exp",    {31'd0, if0.en_exp_o}, 32'd0);
    chk("rst async redir_pc",  if0.redirect_pc_o, 32'd0);
    chk("rst async req_ready", {31'd0, if0.req_ready_o}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk_phase(0, 0, none_e, "rst after");
    chk_phase(1, 0, none_e, "rst after");

    // Randomized traffic against the rule model.
    for (int n = 0; n < 150; n++) begin
      int mode;
      mode = $urandom_range(0, 3);
      r.pc = $urandom; r.bd = 1'($urandom); r.store = 1'($urandom);
      r.eret = ($urandom_range(0, 3) == 0); r.intp = ($urandom_range(0, 3) == 0);
      r.addr = $urandom; r.epc_in = $urandom; r.delay = $urandom_range(0, 2);
      if (mode == 0)      r.flags = 13'h0;
      else if (mode == 1) r.flags = 13'h1 << $urandom_range(0, 12);
      else                r.flags = 13'($urandom & $urandom);
      run_req($sformatf("rnd%0d", n), r, model(r, 1'b1), model(r, 1'b0));
    end

    chk("en_exp pulses u0", en_cnt0, en_exp0);
    chk("en_exp pulses u1", en_cnt1, en_exp1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
